spi_master: RTL

SPI master for codec register configuration. It sits directly downstream of the codec configuration sequencer: it accepts one word per `i_enable` request and serialises it MSB-first on SCLK/MOSI under a chip select. It reports completion with a one-cycle `o_done` pulse and holds `o_busy` while a frame is active. It runs SPI mode 3 (CPOL=1, CPHA=1), which is what the codec requires; this includes the all-zero chip-select toggles that switch the codec into SPI mode.

---
 rtl/spi_master.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
`default_nettype none
// spi_master: SPI mode-3 master, one W-bit MSB-first frame per i_enable request.
// Optional macro SPI_MASTER_READBACK_EN adds MISO capture into o_data.
module spi_master #(
   parameter int SPI_DATA_WIDTH = 32,
   parameter int CLK_DIV        = 4,
   parameter int CS_GAP         = 4
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_enable,
   input  logic [SPI_DATA_WIDTH-1:0] i_data,
   output logic                      o_done,
   output logic                      o_busy,
   output logic [SPI_DATA_WIDTH-1:0] o_data,
   output logic                      o_sclk,
   output logic                      o_mosi,
   output logic                      o_cs_n,
   input  logic                      i_miso
);
   localparam int W     = SPI_DATA_WIDTH;
   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int BIT_W = $clog2(W);
   localparam int GAP_W = $clog2(CS_GAP) + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_LOW   = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   logic [2:0]       state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [W-1:0]     tx_shift_q, tx_shift_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_end, gap_end, last_bit;

   assign div_end  = (div_cnt_q == DIV_LAST);
   assign gap_end  = (gap_cnt_q == GAP_LAST);
   assign last_bit = (bit_cnt_q == BIT_LAST);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_enable) state_d = S_SETUP;
         S_SETUP: if (div_end)  state_d = S_LOW;
         S_LOW:   if (div_end)  state_d = S_HIGH;
         S_HIGH:  if (div_end)  state_d = last_bit ? S_GAP : S_LOW;
         S_GAP:   if (gap_end)  state_d = S_IDLE;
         default:               state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_cnt_d  = div_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      tx_shift_d = tx_shift_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      if (state_q == S_SETUP || state_q == S_LOW || state_q == S_HIGH)
         div_cnt_d = div_end ? '0 : div_cnt_q + 1'b1;
      case (state_q)
         S_IDLE: if (i_enable) begin
            tx_shift_d = i_data;
            cs_n_d     = 1'b0;
            busy_d     = 1'b1;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            gap_cnt_d  = '0;
         end
         S_SETUP: if (div_end) begin
            sclk_d = 1'b0;
            mosi_d = tx_shift_q[W-1];
         end
         S_LOW: if (div_end) sclk_d = 1'b1;
         S_HIGH: if (div_end) begin
            if (last_bit) begin
               cs_n_d = 1'b1;
               done_d = 1'b1;
            end else begin
               // MOSI moves on the falling SCLK edge, a full half-period before the slave samples
               tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
               mosi_d     = tx_shift_q[W-2];
               sclk_d     = 1'b0;
               bit_cnt_d  = bit_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_end ? '0 : gap_cnt_q + 1'b1;
            if (gap_end) busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         tx_shift_q <= '0;
         sclk_q     <= 1'b1;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         tx_shift_q <= tx_shift_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

`ifdef SPI_MASTER_READBACK_EN
   logic [W-1:0] rx_shift_q, rx_shift_d;
   logic [W-1:0] data_q, data_d;

   // MISO is sampled on the same i_clock edge that raises SCLK
   always_comb begin
      rx_shift_d = rx_shift_q;
      data_d     = data_q;
      if (state_q == S_IDLE && i_enable)
         rx_shift_d = '0;
      if (state_q == S_LOW && div_end)
         rx_shift_d = {rx_shift_q[W-2:0], i_miso};
      if (state_q == S_HIGH && div_end && last_bit)
         data_d = rx_shift_q;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_shift_q <= '0;
         data_q     <= '0;
      end else begin
         rx_shift_q <= rx_shift_d;
         data_q     <= data_d;
      end
   end

   assign o_data = data_q;
`else
   logic unused_miso;
   assign unused_miso = i_miso;
   assign o_data      = '0;
`endif

   assign o_done = done_q;
   assign o_busy = busy_q;
   assign o_sclk = sclk_q;
   assign o_mosi = mosi_q;
   assign o_cs_n = cs_n_q;

endmodule
`default_nettype wire
